// File: rtl/vga_pkg.sv
// Shared constants, colour table and moving-square axis helper for the VGA
// pattern source.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;

  // Element 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_COL = {COL_BLACK, COL_BLUE, COL_RED, COL_MAGENTA,
                                          COL_GREEN, COL_CYAN, COL_YELLOW, COL_WHITE};

  typedef struct packed {
    logic [9:0] pos;
    logic       fwd;
  } axis_t;

  // One frame of square motion on one axis; a bounce flips direction and holds.
  function automatic axis_t axis_step(axis_t a, int unsigned step, int unsigned limit);
    axis_t       r;
    logic [10:0] nxt;
    r   = a;
    nxt = {1'b0, a.pos} + 11'(step);
    if (a.fwd) begin
      if (nxt > 11'(limit)) r.fwd = 1'b0;
      else                  r.pos = nxt[9:0];
    end else begin
      if ({1'b0, a.pos} < 11'(step)) r.fwd = 1'b1;
      else                           r.pos = a.pos - 10'(step);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw button, followed by a one-cycle rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: two-stage pipeline from timing-generator x/y/syncs
// to RGB/DE/HS/VS, with button-selected patterns switching on frame boundaries.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE         = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE         = vga_pkg::V_ACTIVE,
  parameter int unsigned BOX              = 64,
  parameter int unsigned STEP             = 2,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       in_frame,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       pattern_next,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic [1:0] pattern
);
  import vga_pkg::*;

  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam logic        SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  logic [9:0]  x1_q, x1_d, y1_q, y1_d;
  logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [1:0]  pattern_q, pattern_d;
  logic        pending_q, pending_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  axis_t       bx_q, bx_d, by_q, by_d;
  logic        btn_pulse, frame_evt;
  logic [2:0]  bar_idx;
  logic        chk, hit;

  btn_sync u_btn (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (pattern_next),
    .pulse (btn_pulse)
  );

  // vs1_q doubles as the previous-cycle copy of raw vsync for edge detection.
  assign frame_evt = (vsync == SYNC_ACTIVE_HIGH) && (vs1_q != SYNC_ACTIVE_HIGH);

  always_comb begin
    pattern_d   = pattern_q;
    pending_d   = pending_q | btn_pulse;
    frame_cnt_d = frame_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    if (frame_evt) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      bx_d        = axis_step(bx_q, STEP, H_ACTIVE - BOX);
      by_d        = axis_step(by_q, STEP, V_ACTIVE - BOX);
      if (pending_q) begin
        pattern_d = pattern_q + 2'd1;
        pending_d = btn_pulse;
      end
    end
  end

  always_comb begin
    x1_d  = x;
    y1_d  = y;
    de1_d = in_frame;
    hs1_d = hsync;
    vs1_d = vsync;
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (32'(x1_q) >= 32'(i) * BAR_W) bar_idx = 3'(i);
    chk = x1_q[5] ^ y1_q[5];
    hit = ({1'b0, x1_q} >= {1'b0, bx_q.pos}) && ({1'b0, x1_q} < {1'b0, bx_q.pos} + 11'(BOX)) &&
          ({1'b0, y1_q} >= {1'b0, by_q.pos}) && ({1'b0, y1_q} < {1'b0, by_q.pos} + 11'(BOX));
  end

  always_comb begin
    rgb_d = COL_BLACK;
    if (de1_q) begin
      case (pattern_q)
        PAT_BARS:  rgb_d = BAR_COL[bar_idx];
        PAT_CHECK: rgb_d = chk ? COL_WHITE : COL_BLACK;
        PAT_GRAD:  rgb_d = {x1_q[7:4], y1_q[7:4], frame_cnt_q[7:4]};
        default:   rgb_d = hit ? COL_WHITE : COL_BLUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_q        <= '0;
      y1_q        <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= SYNC_IDLE;
      vs1_q       <= SYNC_IDLE;
      rgb_q       <= '0;
      de2_q       <= 1'b0;
      hs2_q       <= SYNC_IDLE;
      vs2_q       <= SYNC_IDLE;
      pattern_q   <= PAT_BARS;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      bx_q        <= '{pos: 10'd0, fwd: 1'b1};
      by_q        <= '{pos: 10'd0, fwd: 1'b1};
    end else begin
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      rgb_q       <= rgb_d;
      de2_q       <= de2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      pattern_q   <= pattern_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
    end
  end

  assign red     = rgb_q[11:8];
  assign green   = rgb_q[7:4];
  assign blue    = rgb_q[3:0];
  assign de      = de2_q;
  assign hs      = hs2_q;
  assign vs      = vs2_q;
  assign pattern = pattern_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: latency, bars, checker, gradient, pattern
// switching, press/frame collision, square bounce and asynchronous reset.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x, y;
  logic       in_frame, hsync, vsync, pattern_next;
  logic [3:0] red, green, blue;
  logic       de, hs, vs;
  logic [1:0] pattern;

  int total = 0;
  int bad   = 0;

  logic [9:0]  bar_x   [12] = '{10'd0, 10'd99, 10'd100, 10'd199, 10'd200, 10'd350,
                                10'd450, 10'd550, 10'd650, 10'd699, 10'd700, 10'd799};
  logic [11:0] bar_exp [12] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000, 12'h000};

  vga_pattern_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .in_frame     (in_frame),
    .hsync        (hsync),
    .vsync        (vsync),
    .pattern_next (pattern_next),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .de           (de),
    .hs           (hs),
    .vs           (vs),
    .pattern      (pattern)
  );

  always #5 clk = ~clk;

  task automatic idle();
    in_frame = 1'b0; x = '0; y = '0; hsync = 1'b0; vsync = 1'b0; pattern_next = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_evt();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) pattern_next = 1'b1;
    repeat (3) @(negedge clk);
    pattern_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py, output logic [11:0] rgb);
    @(negedge clk) begin in_frame = 1'b1; x = px; y = py; end
    @(negedge clk) in_frame = 1'b0;
    @(negedge clk) rgb = {red, green, blue};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    total++;
    if ({red, green, blue, de, hs, vs, pattern} !== 17'd0) begin
      $display("FAIL reset_state rgb=%h de=%b hs=%b vs=%b pat=%0d want all zero",
               {red, green, blue}, de, hs, vs, pattern);
      bad++;
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    @(negedge clk) begin in_frame = 1'b1; x = 10'd150; y = 10'd10; hsync = 1'b1; vsync = 1'b1; end
    @(negedge clk) begin in_frame = 1'b0; hsync = 1'b0; vsync = 1'b0; end
    total++;
    if ({de, hs, vs} !== 3'b000) begin
      $display("FAIL latency_early de/hs/vs=%b want 000", {de, hs, vs});
      bad++;
    end
    @(negedge clk);
    total++;
    if ({de, hs, vs, red, green, blue} !== {3'b111, 12'hFF0}) begin
      $display("FAIL latency_n2 de/hs/vs=%b rgb=%h want 111 ff0", {de, hs, vs}, {red, green, blue});
      bad++;
    end
    @(negedge clk);
    total++;
    if ({de, hs, vs} !== 3'b000) begin
      $display("FAIL latency_after de/hs/vs=%b want 000", {de, hs, vs});
      bad++;
    end
  endtask

  task automatic test_bars();
    logic [11:0] rgb;
    for (int i = 0; i < 12; i++) begin
      pix(bar_x[i], 10'd20, rgb);
      total++;
      if (rgb !== bar_exp[i]) begin
        $display("FAIL bar x=%0d got=%h want=%h", bar_x[i], rgb, bar_exp[i]);
        bad++;
      end
    end
    @(negedge clk) begin in_frame = 1'b0; x = 10'd150; end
    repeat (2) @(negedge clk);
    total++;
    if ({de, red, green, blue} !== 13'd0) begin
      $display("FAIL blanking de=%b rgb=%h want 0 000", de, {red, green, blue});
      bad++;
    end
  endtask

  task automatic test_checker();
    logic [9:0]  cx [4] = '{10'd32, 10'd32, 10'd0, 10'd31};
    logic [9:0]  cy [4] = '{10'd0, 10'd32, 10'd0, 10'd32};
    logic [11:0] ce [4] = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};
    logic [11:0] rgb;
    press();
    frame_evt();
    total++;
    if (pattern !== 2'd1) begin
      $display("FAIL checker_select pattern=%0d want 1", pattern);
      bad++;
    end
    for (int i = 0; i < 4; i++) begin
      pix(cx[i], cy[i], rgb);
      total++;
      if (rgb !== ce[i]) begin
        $display("FAIL checker x=%0d y=%0d got=%h want=%h", cx[i], cy[i], rgb, ce[i]);
        bad++;
      end
    end
  endtask

  task automatic test_switching();
    logic [1:0] want [3] = '{2'd2, 2'd3, 2'd0};
    do_reset();
    repeat (3) press();
    total++;
    if (pattern !== 2'd0) begin
      $display("FAIL switch_hold pattern=%0d want 0", pattern);
      bad++;
    end
    frame_evt();
    total++;
    if (pattern !== 2'd1) begin
      $display("FAIL switch_once pattern=%0d want 1", pattern);
      bad++;
    end
    frame_evt();
    total++;
    if (pattern !== 2'd1) begin
      $display("FAIL switch_no_repeat pattern=%0d want 1", pattern);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      press();
      frame_evt();
      total++;
      if (pattern !== want[i]) begin
        $display("FAIL switch_seq pattern=%0d want %0d", pattern, want[i]);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press();
    // Press edge reaches the control logic on the same cycle as the vsync edge.
    @(negedge clk) pattern_next = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    total++;
    if (pattern !== 2'd1) begin
      $display("FAIL collide_first pattern=%0d want 1", pattern);
      bad++;
    end
    pattern_next = 1'b0;
    repeat (3) @(negedge clk);
    frame_evt();
    total++;
    if (pattern !== 2'd2) begin
      $display("FAIL collide_carry pattern=%0d want 2", pattern);
      bad++;
    end
    frame_evt();
    total++;
    if (pattern !== 2'd2) begin
      $display("FAIL collide_settle pattern=%0d want 2", pattern);
      bad++;
    end
  endtask

  task automatic test_gradient_reset();
    logic [11:0] rgb;
    do_reset();
    repeat (2) begin press(); frame_evt(); end
    repeat (35) frame_evt();
    pix(10'h05A, 10'h03C, rgb);
    total++;
    if (rgb !== 12'h532 || pattern !== 2'd2) begin
      $display("FAIL gradient rgb=%h pat=%0d want 532 2", rgb, pattern);
      bad++;
    end
    @(negedge clk) begin in_frame = 1'b1; hsync = 1'b1; vsync = 1'b1; end
    repeat (2) @(negedge clk);
    total++;
    if ({de, hs, vs} !== 3'b111) begin
      $display("FAIL pre_reset de/hs/vs=%b want 111", {de, hs, vs});
      bad++;
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({red, green, blue, de, hs, vs, pattern} !== 17'd0) begin
      $display("FAIL async_reset rgb=%h de=%b hs=%b vs=%b pat=%0d want all zero",
               {red, green, blue}, de, hs, vs, pattern);
      bad++;
    end
    idle();
    @(negedge clk) reset_n = 1'b1;
    repeat (2) begin press(); frame_evt(); end
    pix(10'h05A, 10'h03C, rgb);
    total++;
    if (rgb !== 12'h530) begin
      $display("FAIL frame_cnt_cleared rgb=%h want 530", rgb);
      bad++;
    end
    press();
    frame_evt();
    pix(10'd6, 10'd6, rgb);
    total++;
    if (rgb !== 12'hFFF) begin
      $display("FAIL box_origin_in rgb=%h want fff", rgb);
      bad++;
    end
    pix(10'd5, 10'd6, rgb);
    total++;
    if (rgb !== 12'h00F) begin
      $display("FAIL box_origin_left rgb=%h want 00f", rgb);
      bad++;
    end
    pix(10'd70, 10'd6, rgb);
    total++;
    if (rgb !== 12'h00F) begin
      $display("FAIL box_origin_right rgb=%h want 00f", rgb);
      bad++;
    end
  endtask

  task automatic test_bounce();
    logic [11:0] rgb;
    do_reset();
    repeat (3) begin press(); frame_evt(); end
    for (int k = 4; k <= 370; k++) begin
      frame_evt();
      if (k == 269) begin
        pix(10'd540, 10'd536, rgb);
        total++;
        if (rgb !== 12'hFFF) begin $display("FAIL bounce_y_hold_top k=%0d got=%h want fff", k, rgb); bad++; end
        pix(10'd540, 10'd535, rgb);
        total++;
        if (rgb !== 12'h00F) begin $display("FAIL bounce_y_hold_above k=%0d got=%h want 00f", k, rgb); bad++; end
      end
      if (k == 270) begin
        pix(10'd540, 10'd534, rgb);
        total++;
        if (rgb !== 12'hFFF) begin $display("FAIL bounce_y_back k=%0d got=%h want fff", k, rgb); bad++; end
        pix(10'd540, 10'd598, rgb);
        total++;
        if (rgb !== 12'h00F) begin $display("FAIL bounce_y_bottom k=%0d got=%h want 00f", k, rgb); bad++; end
      end
      if (k == 368 || k == 369) begin
        pix(10'd736, 10'd350, rgb);
        total++;
        if (rgb !== 12'hFFF) begin $display("FAIL bounce_x_peak k=%0d got=%h want fff", k, rgb); bad++; end
        pix(10'd735, 10'd350, rgb);
        total++;
        if (rgb !== 12'h00F) begin $display("FAIL bounce_x_peak_left k=%0d got=%h want 00f", k, rgb); bad++; end
      end
      if (k == 370) begin
        pix(10'd734, 10'd350, rgb);
        total++;
        if (rgb !== 12'hFFF) begin $display("FAIL bounce_x_back k=%0d got=%h want fff", k, rgb); bad++; end
        pix(10'd798, 10'd350, rgb);
        total++;
        if (rgb !== 12'h00F) begin $display("FAIL bounce_x_right k=%0d got=%h want 00f", k, rgb); bad++; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bars();
    test_checker();
    test_switching();
    test_back_to_back();
    test_gradient_reset();
    test_bounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Pixel-source stage between the VGA timing generator and the registered PMOD DVI output pins, in the 40 MHz pixel domain. Consumes x, y, in_frame, hsync and vsync, and produces 12-bit RGB plus DE, HS and VS, all aligned to a fixed 2-cycle pipeline. Generates four selectable test patterns, one of them animated. A button input cycles through the patterns, and a change only takes effect at a frame boundary.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
BOX, 64, side length of the moving square, in pixels
STEP, 2, square displacement per frame, in pixels per axis
SYNC_ACTIVE_HIGH, 1, polarity of hsync/vsync at both input and output (1 = active high)

Ports:
clk  in  1  pixel clock, 40 MHz
reset_n  in  1  asynchronous, active-low reset
x  in  10  horizontal pixel position; valid only while in_frame=1
y  in  10  vertical line position; valid only while in_frame=1
in_frame  in  1  high during the active video area
hsync  in  1  horizontal sync from the timing generator
vsync  in  1  vertical sync from the timing generator
pattern_next  in  1  raw button input; asynchronous, not debounced
red  out  4  pixel red component
green  out  4  pixel green component
blue  out  4  pixel blue component
de  out  1  data enable (in_frame delayed by 2 cycles)
hs  out  1  hsync delayed by 2 cycles
vs  out  1  vsync delayed by 2 cycles
pattern  out  2  pattern currently displayed

Behaviour:
- Reset: asynchronous and active-low on reset_n; all state clears immediately.
  - red, green, blue, de = 0.
  - hs, vs = inactive level (0 when SYNC_ACTIVE_HIGH=1).
  - pattern = 0, frame_cnt = 0, pending = 0.
  - Moving square at (0,0), direction +x, +y.
  - Synchroniser and sync-edge registers cleared to their inactive levels.
- Pipeline latency is exactly 2 clocks. Output at cycle N+2 reflects inputs sampled at cycle N.
  - Stage 1: register the inputs; compute bar index, checker bit and square hit.
  - Stage 2: register the RGB result.
  - in_frame, hsync and vsync pass through two flops with no logic, so RGB and sync stay aligned.
- Blanking: when the delayed in_frame is 0, red/green/blue = 0.
- Pattern 0, colour bars: bar width = H_ACTIVE/8, giving bars at x = 0-99, 100-199, and so on.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each component is either 4'hF or 4'h0.
  - Bar index comes from a comparator chain; no divider.
- Pattern 1, checkerboard: (x[5]^y[5]) ? FFF : 000.
- Pattern 2, gradient: red = x[7:4], green = y[7:4], blue = frame_cnt[7:4].
- Pattern 3, moving square:
  - FFF where box_x <= x < box_x+BOX and box_y <= y < box_y+BOX.
  - Background 00F elsewhere.
- Frame event: one-cycle pulse on the inactive-to-active edge of the raw vsync input. On a frame event:
  - frame_cnt increments; it is 8 bits and wraps 255 -> 0.
  - If pending=1: pattern <= pattern+1 (mod 4, so 3 -> 0) and pending <= 0.
  - The square updates, per axis (x shown; y uses V_ACTIVE):
    - dir +: if box_x+STEP > H_ACTIVE-BOX, flip dir and hold position; else box_x += STEP.
    - dir -: if box_x < STEP, flip dir and hold position; else box_x -= STEP.
- Button handling: pattern_next → 2-FF synchroniser → rising-edge detect.
  - A detected edge sets pending.
  - Any number of presses within one frame produce one pattern advance.
  - If a press and a frame event occur in the same cycle, the advance is applied and pending ends at 1, so the press is carried to the next frame.
- Reset mid-frame: outputs go to their reset values at once. After reset_n releases, the first valid RGB appears 2 cycles after the next in_frame=1 sample.

Decomposition:
- Shared package vga_pkg:
  - Timing constants H_ACTIVE=800, V_ACTIVE=600.
  - Pattern constants PAT_BARS=0, PAT_CHECK=1, PAT_GRAD=2, PAT_BOX=3.
  - 12-bit colour constants for the eight bars.
- One sub-module, btn_sync: 2-FF synchroniser plus rising-edge pulse, with async active-low reset. It is reused for other buttons on the board.

Test Plan:
- Latency: drive in_frame=1, x=150, y=10 at cycle N with pattern 0 → at cycle N+2, de=1 and RGB=FF0 (yellow). hs/vs toggled at cycle N appear at cycle N+2.
- Bar edges: pattern 0, x = 0, 99, 100, 799 → RGB = FFF, FFF, FF0, 000. With in_frame=0 → RGB=000 and de=0.
- Pattern switching: pulse pattern_next 3 times mid-frame → pattern stays 0 until the next vsync rising edge, then becomes 1 (not 3). Press 4 times across separate frames → 1, 2, 3, 0.
- Bounce: pattern 3, run 370 frame events → box_x peaks at 736 (800-64), flips, then decreases by 2 per frame. box_y holds at 536 for one frame when it flips.
- Simultaneous press and frame event: the press edge lands on the vsync-edge cycle → pattern advances by 1 and pending=1, so it advances again at the next frame.
- Reset mid-operation: pattern=2, frame_cnt=37, assert reset_n=0 asynchronously between clock edges → outputs go to 0 and the inactive sync level immediately, pattern=0, frame_cnt=0, square at (0,0).
